// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-8 demultiplexer.
//   NUM_CH           : number of output channels
//   SEL_W            : width of the channel select
//   DEFAULT_BUSWIDTH : default data width
//   slot_state_t     : per-channel slot occupancy
//   sel_decode()     : select -> one-hot channel mask
package demux_pkg;

    localparam int unsigned NUM_CH           = 8;
    localparam int unsigned SEL_W            = 3;
    localparam int unsigned DEFAULT_BUSWIDTH = 32;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot for a single demux channel.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   load      : input transfer addressed to this channel
//   wdata     : word to store on load
//   out_ready : consumer takes the word this cycle
//   out_valid : slot holds a word
//   out_data  : slot contents (holds last value while empty)
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned buswidth = DEFAULT_BUSWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [buswidth-1:0] wdata,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [buswidth-1:0] out_data
);

    slot_state_t         state;
    slot_state_t         state_next;
    logic [buswidth-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                data_q <= wdata;
            end
        end
    end

    // A load always wins over a drain: a full slot drained and refilled in
    // the same cycle stays full with the new word.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end else if (out_ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    assign out_valid = (state == SLOT_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/demux8_reg.sv
// Registered 1-to-8 demultiplexer with a one-entry slot per channel.
//   clk, rst_n                : clock, synchronous active-low reset
//   in_valid/in_ready         : producer handshake
//   in_select, in_data        : destination channel and word
//   out_valid[k]/out_ready[k] : per-channel consumer handshake
//   out_data0..out_data7      : per-channel slot contents
module demux8_reg
    import demux_pkg::*;
#(
    parameter int unsigned buswidth = DEFAULT_BUSWIDTH,
    parameter int unsigned selwidth = SEL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [selwidth-1:0] in_select,
    input  logic [buswidth-1:0] in_data,
    output logic [NUM_CH-1:0]   out_valid,
    input  logic [NUM_CH-1:0]   out_ready,
    output logic [buswidth-1:0] out_data0,
    output logic [buswidth-1:0] out_data1,
    output logic [buswidth-1:0] out_data2,
    output logic [buswidth-1:0] out_data3,
    output logic [buswidth-1:0] out_data4,
    output logic [buswidth-1:0] out_data5,
    output logic [buswidth-1:0] out_data6,
    output logic [buswidth-1:0] out_data7
);

    logic [NUM_CH-1:0]   load;
    logic                in_fire;
    logic [buswidth-1:0] slot_data [NUM_CH];

    // Readiness looks only at the addressed slot, so a stalled consumer
    // blocks only words headed for its own channel.
    assign in_ready = rst_n && (!out_valid[in_select] || out_ready[in_select]);
    assign in_fire  = in_valid && in_ready;
    assign load     = in_fire ? sel_decode(in_select) : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .buswidth(buswidth)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .wdata    (in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (slot_data[k])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];
    assign out_data4 = slot_data[4];
    assign out_data5 = slot_data[5];
    assign out_data6 = slot_data[6];
    assign out_data7 = slot_data[7];

endmodule

// File: tb/tb_demux8_reg.sv
module tb_demux8_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_select;
    logic [31:0] in_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [31:0] od [8];

    int n_cmp = 0;
    int n_err = 0;

    demux8_reg #(
        .buswidth(32),
        .selwidth(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_select(in_select),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data0(od[0]),
        .out_data1(od[1]),
        .out_data2(od[2]),
        .out_data3(od[3]),
        .out_data4(od[4]),
        .out_data5(od[5]),
        .out_data6(od[6]),
        .out_data7(od[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [7:0]  ordy;
        logic        erdy;   // in_ready before the edge
        logic [7:0]  eov;    // out_valid after the edge
        int          ch;     // channel whose data is checked after the edge
        logic [31:0] ed;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] s,
                         input logic [31:0] d, input logic [7:0] o);
        rst_n     = r;
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = o;
    endtask

    initial begin
        vec[0]  = '{1'b0, 1'b1, 3'd5, 32'hAAAAAAAA, 8'h00, 1'b0, 8'h00, 5, 32'h0};
        vec[1]  = '{1'b0, 1'b1, 3'd5, 32'hAAAAAAAA, 8'h00, 1'b0, 8'h00, 0, 32'h0};
        vec[2]  = '{1'b1, 1'b0, 3'd5, 32'h0,        8'h00, 1'b1, 8'h00, 5, 32'h0};
        vec[3]  = '{1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b1, 8'h20, 5, 32'hDEADBEEF};
        vec[4]  = '{1'b1, 1'b1, 3'd5, 32'h11111111, 8'h00, 1'b0, 8'h20, 5, 32'hDEADBEEF};
        vec[5]  = '{1'b1, 1'b1, 3'd2, 32'h22222222, 8'h00, 1'b1, 8'h24, 2, 32'h22222222};
        vec[6]  = '{1'b1, 1'b1, 3'd5, 32'h55555555, 8'h20, 1'b1, 8'h24, 5, 32'h55555555};
        vec[7]  = '{1'b1, 1'b0, 3'd0, 32'h0,        8'h04, 1'b1, 8'h20, 2, 32'h22222222};
        vec[8]  = '{1'b1, 1'b1, 3'd0, 32'h0A0A0A0A, 8'h00, 1'b1, 8'h21, 0, 32'h0A0A0A0A};
        vec[9]  = '{1'b1, 1'b1, 3'd4, 32'h44444444, 8'h00, 1'b1, 8'h31, 4, 32'h44444444};
        vec[10] = '{1'b1, 1'b1, 3'd7, 32'h77777777, 8'h00, 1'b1, 8'hB1, 7, 32'h77777777};
        vec[11] = '{1'b1, 1'b0, 3'd0, 32'h0,        8'h91, 1'b1, 8'h20, 7, 32'h77777777};
        vec[12] = '{1'b1, 1'b0, 3'd5, 32'h0,        8'h20, 1'b1, 8'h00, 5, 32'h55555555};
        vec[13] = '{1'b1, 1'b1, 3'd6, 32'h66666666, 8'hFF, 1'b1, 8'h40, 6, 32'h66666666};
        vec[14] = '{1'b1, 1'b0, 3'd6, 32'h0,        8'h00, 1'b0, 8'h40, 6, 32'h66666666};

        drive(1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
        @(posedge clk);
        #1;

        // Table: reset, routing, back-pressure, drain+refill, parallel drain
        for (int i = 0; i < 15; i++) begin
            drive(vec[i].rst, vec[i].v, vec[i].sel, vec[i].data, vec[i].ordy);
            @(negedge clk);
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vec[i].erdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vec[i].eov));
            check($sformatf("v%0d out_data%0d", i, vec[i].ch), od[vec[i].ch], vec[i].ed);
        end

        // Streaming 1..16 into channel 3 with its consumer always ready
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, 3'd3, 32'(i), 8'h08);
            @(negedge clk);
            check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d valid3", i), 32'(out_valid[3]), 32'd1);
            check($sformatf("stream%0d data3", i), od[3], 32'(i));
        end
        drive(1'b1, 1'b0, 3'd3, 32'h0, 8'h08);
        @(posedge clk);
        #1;
        check("stream drain out_valid", 32'(out_valid), 32'h40);

        // Reset mid-operation with four channels full and a word in flight
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 3'(k), 32'hC0DE0000 + 32'(k), 8'h00);
            @(posedge clk);
            #1;
        end
        check("prereset out_valid", 32'(out_valid), 32'h4F);
        check("prereset data2", od[2], 32'hC0DE0002);
        drive(1'b0, 1'b1, 3'd4, 32'hBADBAD00, 8'h00);
        @(negedge clk);
        check("midreset in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midreset out_valid", 32'(out_valid), 32'h00);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("midreset data%0d", k), od[k], 32'h0);
        end
        drive(1'b1, 1'b0, 3'd4, 32'hBADBAD00, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("postreset%0d out_valid", c), 32'(out_valid), 32'h00);
            check($sformatf("postreset%0d data4", c), od[4], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
